// File: rtl/multicycle_control_seq.sv
// Multicycle control sequencer for the i281 datapath.
// Walks each instruction through IF/ID/EX/MEM/WB states and emits the control
// vector c[CTRL_W:1] plus register-file selects from the current state and the
// instruction latched during ID.
module multicycle_control_seq #(
  parameter int RSEL_W   = 2,
  parameter int CTRL_W   = 24,
  parameter int MEM_WAIT = 1,
  parameter int STEP_EN  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    step_mode,
  input  logic [22+2*RSEL_W:0]    opcode_in,
  input  logic [3:0]              flags_reg,
  input  logic                    mem_ready,
  output logic [CTRL_W:1]         c,
  output logic [RSEL_W-1:0]       rd_a_sel,
  output logic [RSEL_W-1:0]       rd_b_sel,
  output logic [RSEL_W-1:0]       wr_sel,
  output logic [3:0]              state_out,
  output logic                    instr_done,
  output logic                    illegal_op,
  output logic                    busy
);

  localparam int OPW = 23 + 2*RSEL_W;

  // One-hot opcode bit positions (i281 decoder order)
  localparam int OP_NOOP    = 0;
  localparam int OP_INPUTC  = 1;
  localparam int OP_INPUTCF = 2;
  localparam int OP_INPUTD  = 3;
  localparam int OP_INPUTDF = 4;
  localparam int OP_MOVE    = 5;
  localparam int OP_LOADI   = 6;
  localparam int OP_ADD     = 7;
  localparam int OP_ADDI    = 8;
  localparam int OP_SUB     = 9;
  localparam int OP_SUBI    = 10;
  localparam int OP_LOAD    = 11;
  localparam int OP_LOADF   = 12;
  localparam int OP_STORE   = 13;
  localparam int OP_STOREF  = 14;
  localparam int OP_SHIFTL  = 15;
  localparam int OP_SHIFTR  = 16;
  localparam int OP_CMP     = 17;
  localparam int OP_JUMP    = 18;
  localparam int OP_BRE     = 19;
  localparam int OP_BRNE    = 20;
  localparam int OP_BRG     = 21;
  localparam int OP_BRGE    = 22;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_IF      = 4'd1,
    S_ID      = 4'd2,
    S_EX_ALU  = 4'd3,
    S_EX_IMM  = 4'd4,
    S_EX_ADDR = 4'd5,
    S_EX_JUMP = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_ALU  = 4'd9,
    S_WB_LOAD = 4'd10
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_run_prev;
  logic [22:0]         r_op;
  logic [RSEL_W-1:0]   r_rx;
  logic [RSEL_W-1:0]   r_ry;

  logic [22:0]         w_op_raw;
  logic [22:0]         w_op_dec;
  logic [RSEL_W-1:0]   w_rx;
  logic [RSEL_W-1:0]   w_ry;
  logic                w_legal;
  logic                w_br_taken;
  logic                w_step;
  logic                w_go;
  logic                w_mem_go;
  state_t              w_end_next;
  logic [24:1]         w_c;
  logic                w_unused;

  assign w_op_raw = opcode_in[22:0];
  assign w_rx     = opcode_in[OPW-1 -: RSEL_W];
  assign w_ry     = opcode_in[OPW-1-RSEL_W -: RSEL_W];

  // Exactly one bit set; anything else decodes as NOOP
  assign w_legal  = (w_op_raw != 23'd0) && ((w_op_raw & (w_op_raw - 23'd1)) == 23'd0);
  assign w_op_dec = w_legal ? w_op_raw : 23'd1;

  assign w_br_taken = (w_op_dec[OP_BRE]  &  flags_reg[0])
                    | (w_op_dec[OP_BRNE] & ~flags_reg[0])
                    | (w_op_dec[OP_BRG]  & ~flags_reg[0] & ~flags_reg[1])
                    | (w_op_dec[OP_BRGE] & ~flags_reg[1]);

  assign w_step     = (STEP_EN != 0) && step_mode;
  assign w_go       = w_step ? (run & ~r_run_prev) : run;
  assign w_mem_go   = (MEM_WAIT == 0) || mem_ready;
  assign w_end_next = (!run || w_step) ? S_IDLE : S_IF;

  // Flag bits O/C and most latched opcode bits have no effect on sequencing
  assign w_unused = ^{flags_reg[3:2], r_op};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Previous run level for rising-edge detection in step mode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_run_prev <= 1'b0;
    else       r_run_prev <= run;
  end

  // Instruction register, loaded while in ID
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op <= '0;
      r_rx <= '0;
      r_ry <= '0;
    end else if (r_state == S_ID) begin
      r_op <= w_op_dec;
      r_rx <= w_rx;
      r_ry <= w_ry;
    end
  end

  // Next-state, control vector and select decode
  always_comb begin
    w_state_next = r_state;
    w_c          = '0;
    rd_a_sel     = '0;
    rd_b_sel     = '0;
    wr_sel       = '0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    if (r_state != S_IDLE && r_state != S_IF) begin
      rd_a_sel = r_rx;
      rd_b_sel = r_ry;
    end
    case (r_state)
      S_IDLE: if (w_go) w_state_next = S_IF;
      S_IF: begin
        w_c[3] = 1'b1; w_c[12] = 1'b1; w_c[16] = 1'b1; w_c[20] = 1'b1; w_c[22] = 1'b1;
        w_state_next = S_ID;
      end
      S_ID: begin
        w_c[3] = 1'b1; w_c[11] = 1'b1; w_c[12] = 1'b1; w_c[15] = 1'b1; w_c[22] = 1'b1;
        illegal_op = ~w_legal;
        if (w_op_dec[OP_JUMP] || w_br_taken)
          w_state_next = S_EX_JUMP;
        else if (w_op_dec[OP_MOVE] || w_op_dec[OP_ADD] || w_op_dec[OP_SUB] ||
                 w_op_dec[OP_SHIFTL] || w_op_dec[OP_SHIFTR] || w_op_dec[OP_CMP])
          w_state_next = S_EX_ALU;
        else if (w_op_dec[OP_ADDI] || w_op_dec[OP_SUBI] || w_op_dec[OP_LOADI])
          w_state_next = S_EX_IMM;
        else if (w_op_dec[OP_LOAD] || w_op_dec[OP_LOADF] || w_op_dec[OP_STORE] ||
                 w_op_dec[OP_STOREF] || w_op_dec[OP_INPUTC] || w_op_dec[OP_INPUTCF] ||
                 w_op_dec[OP_INPUTD] || w_op_dec[OP_INPUTDF])
          w_state_next = S_EX_ADDR;
        else begin
          // NOOP, illegal opcode, or branch not taken
          instr_done   = 1'b1;
          w_state_next = w_end_next;
        end
      end
      S_EX_ALU: begin
        w_c[14] = 1'b1; w_c[21] = 1'b1; w_c[22] = 1'b1; w_c[24] = 1'b1;
        w_c[13] = r_op[OP_SUB] | r_op[OP_CMP] | r_op[OP_SHIFTR];
        if (r_op[OP_CMP]) begin
          instr_done   = 1'b1;
          w_state_next = w_end_next;
        end else begin
          w_state_next = S_WB_ALU;
        end
      end
      S_EX_IMM: begin
        w_c[12] = 1'b1; w_c[14] = 1'b1; w_c[19] = 1'b1; w_c[22] = 1'b1; w_c[24] = 1'b1;
        w_c[13] = r_op[OP_SUBI];
        w_state_next = S_WB_ALU;
      end
      S_EX_ADDR: begin
        w_c[12] = 1'b1; w_c[14] = 1'b1; w_c[19] = 1'b1; w_c[22] = 1'b1; w_c[24] = 1'b1;
        w_state_next = (r_op[OP_LOAD] || r_op[OP_LOADF]) ? S_MEM_RD : S_MEM_WR;
      end
      S_EX_JUMP: begin
        w_c[2] = 1'b1; w_c[3] = 1'b1;
        instr_done   = 1'b1;
        w_state_next = w_end_next;
      end
      S_MEM_RD: begin
        w_c[23] = 1'b1;
        if (w_mem_go) w_state_next = S_WB_LOAD;
      end
      S_MEM_WR: begin
        w_c[17] = 1'b1;
        if (w_mem_go) begin
          instr_done   = 1'b1;
          w_state_next = w_end_next;
        end
      end
      S_WB_ALU: begin
        w_c[10] = 1'b1;
        wr_sel       = r_rx;
        instr_done   = 1'b1;
        w_state_next = w_end_next;
      end
      S_WB_LOAD: begin
        w_c[10] = 1'b1; w_c[18] = 1'b1;
        wr_sel       = r_rx;
        instr_done   = 1'b1;
        w_state_next = w_end_next;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign c[24:1] = w_c;

  generate
    if (CTRL_W > 24) begin : g_pad
      assign c[CTRL_W:25] = '0;
    end
  endgenerate

  assign state_out = r_state;
  assign busy      = (r_state != S_IDLE);

endmodule
